// File: rtl/mmio_fabric_pkg.sv
// Shared definitions for the MMIO fabric: access-size encodings, FSM state
// encodings, the default error read word and small decode helpers.
package mmio_fabric_pkg;

    // cpu_size[1:0] encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Fabric FSM states
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Reserved size or a misaligned half/word access cannot be issued to a slave
    function automatic logic access_illegal(input logic [1:0] sz, input logic [1:0] alo);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = alo[0];
            SZ_WORD: bad = (alo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Error counter increments and sticks at its maximum
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_lane_align.sv
// Byte-lane steering for the MMIO fabric (purely combinational).
//   size_i   [2:0]  u,b/h/w access size
//   addr_i   [1:0]  byte offset within the word
//   wdata_i  [31:0] right-aligned CPU write data
//   rword_i  [31:0] raw slave read word
//   wdata_o  [31:0] lane-replicated write data
//   be_o     [3:0]  byte enables
//   rdata_o  [31:0] shifted and sign/zero-extended read data
module mmio_lane_align
    import mmio_fabric_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted_s;

    // Write replication and byte-enable generation
    always_comb begin
        wdata_o = 32'h0;
        be_o    = 4'b0000;
        case (size_i[1:0])
            SZ_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                be_o    = 4'b0001 << addr_i;
            end
            SZ_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                wdata_o = wdata_i;
                be_o    = 4'b1111;
            end
            default: begin
                wdata_o = 32'h0;
                be_o    = 4'b0000;
            end
        endcase
    end

    // Read alignment: bring the addressed lane to bit 0, then extend
    always_comb begin
        shifted_s = rword_i >> {addr_i, 3'b000};
        rdata_o   = 32'h0;
        case (size_i[1:0])
            SZ_BYTE: begin
                if (size_i[2]) begin
                    rdata_o = {24'h0, shifted_s[7:0]};
                end else begin
                    rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_HALF: begin
                if (size_i[2]) begin
                    rdata_o = {16'h0, shifted_s[15:0]};
                end else begin
                    rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_WORD: rdata_o = shifted_s;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mmio_fabric.sv
// MMIO fabric between the CPU data port and NUM_SLAVES peripherals.
// Decodes a configurable region map, steers byte lanes, runs a req/ready
// handshake with each slave, times out stuck slaves and logs bus errors.
//   clk, reset_n                 clock, async active-low reset
//   cpu_req/we/addr/wdata/size   CPU request (held until cpu_ready)
//   cpu_ready/rdata/err          one-cycle response
//   s_req/we/addr/wdata/be       slave-side request (s_req one-hot)
//   s_rdata/s_ready              slave responses, slave k at [32k+:32] / [k]
//   err_addr/err_count           last errored address, saturating count
module mmio_fabric
    import mmio_fabric_pkg::*;
#(
    parameter int unsigned                NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = {NUM_SLAVES{32'hFF}},
    parameter int unsigned                TIMEOUT    = 255,
    parameter logic [31:0]                ERR_RDATA  = ERR_RDATA_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic [2:0]                cpu_size,
    output logic                      cpu_ready,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_err,
    output logic [NUM_SLAVES-1:0]     s_req,
    output logic                      s_we,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_be,
    input  logic [NUM_SLAVES*32-1:0]  s_rdata,
    input  logic [NUM_SLAVES-1:0]     s_ready,
    output logic [31:0]               err_addr,
    output logic [7:0]                err_count
);

    logic [1:0]            state_q, state_d;
    logic [2:0]            tgt_q, tgt_d;
    logic                  we_q, we_d;
    logic [2:0]            size_q, size_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] s_req_q, s_req_d;
    logic                  s_we_q, s_we_d;
    logic [31:0]           s_addr_q, s_addr_d;
    logic [31:0]           s_wdata_q, s_wdata_d;
    logic [3:0]            s_be_q, s_be_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  cpu_err_q, cpu_err_d;
    logic [31:0]           cpu_rdata_q, cpu_rdata_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  hit_s;
    logic [2:0]            hit_idx_s;
    logic [31:0]           hit_mask_s;
    logic [NUM_SLAVES-1:0] hit_onehot_s;
    logic [31:0]           sel_rdata_s;
    logic                  sel_ready_s;
    logic [2:0]            align_size_s;
    logic [1:0]            align_addr_s;
    logic [31:0]           align_wdata_s;
    logic [3:0]            align_be_s;
    logic [31:0]           align_rdata_s;
    logic [31:0]           cnt_inc_s;
    logic                  expire_s;

    // Region decode: first (lowest-index) matching region wins
    always_comb begin
        hit_s        = 1'b0;
        hit_idx_s    = 3'd0;
        hit_mask_s   = 32'h0;
        hit_onehot_s = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (!hit_s && ((cpu_addr & ~SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32])) begin
                hit_s           = 1'b1;
                hit_idx_s       = 3'(k);
                hit_mask_s      = SLAVE_MASK[32*k +: 32];
                hit_onehot_s[k] = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Pick the active slave's read word and ready; ready only counts while requested
    always_comb begin
        sel_rdata_s = 32'h0;
        sel_ready_s = 1'b0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (tgt_q == 3'(k)) begin
                sel_rdata_s = s_rdata[32*k +: 32];
                sel_ready_s = s_ready[k] & s_req_q[k];
            end else begin
                sel_ready_s = sel_ready_s;
            end
        end
    end

    // One aligner serves both directions: live CPU fields while decoding,
    // the captured fields once the access is in flight.
    assign align_size_s = (state_q == ST_IDLE) ? cpu_size       : size_q;
    assign align_addr_s = (state_q == ST_IDLE) ? cpu_addr[1:0]  : addr_q[1:0];

    mmio_lane_align u_align (
        .size_i  (align_size_s),
        .addr_i  (align_addr_s),
        .wdata_i (cpu_wdata),
        .rword_i (sel_rdata_s),
        .wdata_o (align_wdata_s),
        .be_o    (align_be_s),
        .rdata_o (align_rdata_s)
    );

    // Expiry is judged on the incremented count so s_req stays up exactly TIMEOUT cycles
    assign cnt_inc_s = cnt_q + 32'd1;
    assign expire_s  = (TIMEOUT != 0) && (cnt_inc_s == 32'(TIMEOUT));

    // Transaction FSM and next-state for every register
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        s_req_d     = s_req_q;
        s_we_d      = s_we_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_be_d      = s_be_q;
        cpu_ready_d = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    tgt_d     = hit_idx_s;
                    we_d      = cpu_we;
                    size_d    = cpu_size;
                    addr_d    = cpu_addr;
                    cnt_d     = 32'd0;
                    s_we_d    = cpu_we;
                    s_addr_d  = cpu_addr & hit_mask_s;
                    s_wdata_d = align_wdata_s;
                    s_be_d    = align_be_s;
                    if (access_illegal(cpu_size[1:0], cpu_addr[1:0]) || !hit_s) begin
                        state_d     = ST_RESP;
                        s_req_d     = '0;
                        cpu_ready_d = 1'b1;
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = cpu_we ? 32'h0 : ERR_RDATA;
                        err_addr_d  = cpu_addr;
                        err_count_d = sat_inc8(err_count_q);
                    end else begin
                        state_d = ST_ACCESS;
                        s_req_d = hit_onehot_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_inc_s;
                if (sel_ready_s) begin
                    state_d     = ST_RESP;
                    s_req_d     = '0;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = we_q ? 32'h0 : align_rdata_s;
                end else if (expire_s) begin
                    state_d     = ST_RESP;
                    s_req_d     = '0;
                    cpu_ready_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = we_q ? 32'h0 : ERR_RDATA;
                    err_addr_d  = addr_q;
                    err_count_d = sat_inc8(err_count_q);
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
                s_req_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
                s_req_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tgt_q       <= 3'd0;
            we_q        <= 1'b0;
            size_q      <= 3'd0;
            addr_q      <= 32'h0;
            cnt_q       <= 32'd0;
            s_req_q     <= '0;
            s_we_q      <= 1'b0;
            s_addr_q    <= 32'h0;
            s_wdata_q   <= 32'h0;
            s_be_q      <= 4'b0000;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= 32'h0;
            err_addr_q  <= 32'h0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            s_req_q     <= s_req_d;
            s_we_q      <= s_we_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_be_q      <= s_be_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign s_req     = s_req_q;
    assign s_we      = s_we_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_be      = s_be_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mmio_fabric.sv
module tb_mmio_fabric;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we;
    logic [31:0]   cpu_addr, cpu_wdata;
    logic [2:0]    cpu_size;
    logic          cpu_ready, cpu_err;
    logic [31:0]   cpu_rdata;
    logic [3:0]    s_req;
    logic          s_we;
    logic [31:0]   s_addr, s_wdata;
    logic [3:0]    s_be;
    logic [127:0]  s_rdata;
    logic [3:0]    s_ready;
    logic [31:0]   err_addr;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    // slave model controls
    int          slave_wait  = 0;
    logic        slave_never = 1'b0;
    logic [31:0] slave_val   = 32'h0;
    int          scnt        = 0;

    // results of the last transaction
    logic [31:0] t_rd;
    logic        t_err, t_ok, t_ready_after;
    int          t_cyc, t_sreq_cyc;
    logic [3:0]  t_sreq, t_be;
    logic [31:0] t_saddr, t_swdata;

    mmio_fabric #(
        .NUM_SLAVES (4),
        .SLAVE_BASE ({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .SLAVE_MASK ({4{32'h0000_00FF}}),
        .TIMEOUT    (8),
        .ERR_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Slave model: ready after slave_wait cycles of s_req; otherwise junk read data
    initial begin
        s_ready = 4'b0;
        s_rdata = '0;
        forever begin
            @(negedge clk);
            if (s_req != 4'b0 && !slave_never && scnt == slave_wait) begin
                s_ready = s_req;
                s_rdata = {4{slave_val}};
            end else begin
                s_ready = 4'b0;
                s_rdata = {4{32'h0BAD_0000 | 32'(scnt)}};
            end
            if (s_req != 4'b0) scnt++;
            else scnt = 0;
        end
    end

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_size = size;
        t_ok = 1'b0; t_cyc = 0; t_sreq_cyc = 0; t_rd = 32'h0; t_err = 1'b0;
        t_sreq = 4'b0; t_be = 4'b0; t_saddr = 32'h0; t_swdata = 32'h0;
        for (int i = 0; i < 64 && !t_ok; i++) begin
            @(posedge clk); #1;
            t_cyc++;
            if (s_req != 4'b0) begin
                if (t_sreq_cyc == 0) begin
                    t_sreq = s_req; t_saddr = s_addr; t_swdata = s_wdata; t_be = s_be;
                end
                t_sreq_cyc++;
            end
            if (cpu_ready) begin
                t_ok = 1'b1; t_rd = cpu_rdata; t_err = cpu_err;
            end
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        t_ready_after = cpu_ready;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0;
        cpu_wdata = 32'h0; cpu_size = 3'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cpu_ready, cpu_err, s_req, s_we, s_be} !== 11'h0 || cpu_rdata !== 32'h0 ||
            s_addr !== 32'h0 || s_wdata !== 32'h0 || err_addr !== 32'h0 || err_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b s_req=%b rdata=%h err_count=%0d exp all zero",
                     cpu_ready, s_req, cpu_rdata, err_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_word_read;
        slave_never = 1'b0; slave_wait = 0; slave_val = 32'h8899_AABB;
        do_txn(1'b0, 32'h0000_1004, 32'h0, 3'b010);
        checks++;
        if (!t_ok || t_cyc !== 2) begin
            errors++; $display("FAIL word_read_latency got ok=%b cyc=%0d exp cyc=2", t_ok, t_cyc);
        end
        checks++;
        if (t_sreq !== 4'b0010 || t_saddr !== 32'h04 || t_be !== 4'b1111) begin
            errors++; $display("FAIL word_read_slave got s_req=%b s_addr=%h be=%b exp 0010 04 1111",
                               t_sreq, t_saddr, t_be);
        end
        checks++;
        if (t_rd !== 32'h8899_AABB || t_err !== 1'b0) begin
            errors++; $display("FAIL word_read_data got %h err=%b exp 8899aabb err=0", t_rd, t_err);
        end
    endtask

    task automatic test_lanes;
        slave_wait = 0; slave_val = 32'h8011_2233;
        do_txn(1'b0, 32'h0000_1007, 32'h0, 3'b000);
        checks++;
        if (t_rd !== 32'hFFFF_FF80 || t_be !== 4'b1000) begin
            errors++; $display("FAIL lb_signed got %h be=%b exp ffffff80 be=1000", t_rd, t_be);
        end
        do_txn(1'b0, 32'h0000_1007, 32'h0, 3'b100);
        checks++;
        if (t_rd !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu got %h exp 00000080", t_rd);
        end
        do_txn(1'b0, 32'h0000_1002, 32'h0, 3'b001);
        checks++;
        if (t_rd !== 32'hFFFF_8011) begin
            errors++; $display("FAIL lh_signed got %h exp ffff8011", t_rd);
        end
        do_txn(1'b1, 32'h0000_1002, 32'h0000_BEEF, 3'b001);
        checks++;
        if (t_swdata !== 32'hBEEF_BEEF || t_be !== 4'b1100 || t_rd !== 32'h0 || s_we !== 1'b1) begin
            errors++; $display("FAIL sh_steer got wdata=%h be=%b rdata=%h exp beefbeef 1100 0",
                               t_swdata, t_be, t_rd);
        end
        do_txn(1'b1, 32'h0000_3001, 32'h1234_565A, 3'b000);
        checks++;
        if (t_swdata !== 32'h5A5A_5A5A || t_be !== 4'b0010 || t_sreq !== 4'b1000) begin
            errors++; $display("FAIL sb_steer got wdata=%h be=%b s_req=%b exp 5a5a5a5a 0010 1000",
                               t_swdata, t_be, t_sreq);
        end
    endtask

    task automatic test_wait_states;
        slave_wait = 5; slave_val = 32'h1234_5678;
        do_txn(1'b0, 32'h0000_0010, 32'h0, 3'b010);
        checks++;
        if (t_sreq_cyc !== 6 || t_cyc !== 7 || t_sreq !== 4'b0001) begin
            errors++; $display("FAIL wait_sreq got sreq_cycles=%0d cyc=%0d s_req=%b exp 6 7 0001",
                               t_sreq_cyc, t_cyc, t_sreq);
        end
        checks++;
        if (t_rd !== 32'h1234_5678 || t_ready_after !== 1'b0) begin
            errors++; $display("FAIL wait_resp got rdata=%h ready_after=%b exp 12345678 0",
                               t_rd, t_ready_after);
        end
        checks++;
        if (cpu_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL wait_hold got %h exp 12345678", cpu_rdata);
        end
    endtask

    task automatic test_timeout;
        slave_never = 1'b1;
        do_txn(1'b0, 32'h0000_2010, 32'h0, 3'b010);
        checks++;
        if (t_sreq_cyc !== 8 || t_cyc !== 9) begin
            errors++; $display("FAIL timeout_len got sreq_cycles=%0d cyc=%0d exp 8 9", t_sreq_cyc, t_cyc);
        end
        checks++;
        if (t_err !== 1'b1 || t_rd !== 32'hDEAD_BEEF || err_addr !== 32'h0000_2010 || err_count !== 8'd1) begin
            errors++; $display("FAIL timeout_err got err=%b rdata=%h err_addr=%h count=%0d exp 1 deadbeef 2010 1",
                               t_err, t_rd, err_addr, err_count);
        end
        slave_never = 1'b0; slave_wait = 7; slave_val = 32'hCAFE_F00D;
        do_txn(1'b0, 32'h0000_2014, 32'h0, 3'b010);
        checks++;
        if (t_err !== 1'b0 || t_rd !== 32'hCAFE_F00D || t_sreq_cyc !== 8 || err_count !== 8'd1) begin
            errors++; $display("FAIL timeout_race got err=%b rdata=%h sreq_cycles=%0d count=%0d exp 0 cafef00d 8 1",
                               t_err, t_rd, t_sreq_cyc, err_count);
        end
    endtask

    task automatic test_decode_errors;
        slave_wait = 0;
        do_txn(1'b0, 32'h0000_1002, 32'h0, 3'b010);
        checks++;
        if (t_err !== 1'b1 || t_cyc !== 1 || t_sreq_cyc !== 0 || t_rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL misalign got err=%b cyc=%0d sreq_cycles=%0d rdata=%h exp 1 1 0 deadbeef",
                               t_err, t_cyc, t_sreq_cyc, t_rd);
        end
        do_txn(1'b1, 32'h0000_1000, 32'h0, 3'b011);
        checks++;
        if (t_err !== 1'b1 || t_cyc !== 1 || t_sreq_cyc !== 0 || t_rd !== 32'h0) begin
            errors++; $display("FAIL rsvd_size got err=%b cyc=%0d sreq_cycles=%0d rdata=%h exp 1 1 0 0",
                               t_err, t_cyc, t_sreq_cyc, t_rd);
        end
        do_txn(1'b0, 32'h0000_9000, 32'h0, 3'b010);
        checks++;
        if (t_err !== 1'b1 || t_cyc !== 1 || t_sreq_cyc !== 0 || err_addr !== 32'h0000_9000 || err_count !== 8'd4) begin
            errors++; $display("FAIL unmapped got err=%b cyc=%0d sreq_cycles=%0d err_addr=%h count=%0d exp 1 1 0 9000 4",
                               t_err, t_cyc, t_sreq_cyc, err_addr, err_count);
        end
        for (int i = 0; i < 300; i++) begin
            do_txn(1'b0, 32'h0000_9004, 32'h0, 3'b010);
        end
        checks++;
        if (err_count !== 8'd255 || err_addr !== 32'h0000_9004) begin
            errors++; $display("FAIL err_saturate got count=%0d err_addr=%h exp 255 9004", err_count, err_addr);
        end
    endtask

    task automatic test_reset_mid_access;
        slave_never = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2020; cpu_size = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_req !== 4'b0100) begin
            errors++; $display("FAIL pre_reset_sreq got %b exp 0100", s_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (s_req !== 4'b0 || cpu_ready !== 1'b0 || s_be !== 4'b0 || s_addr !== 32'h0 ||
            err_count !== 8'd0 || err_addr !== 32'h0 || cpu_rdata !== 32'h0) begin
            errors++; $display("FAIL async_reset got s_req=%b be=%b s_addr=%h count=%0d rdata=%h exp all zero",
                               s_req, s_be, s_addr, err_count, cpu_rdata);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        slave_never = 1'b0; slave_wait = 1; slave_val = 32'h0F0E_0D0C;
        do_txn(1'b0, 32'h0000_2020, 32'h0, 3'b010);
        checks++;
        if (!t_ok || t_err !== 1'b0 || t_rd !== 32'h0F0E_0D0C || t_cyc !== 3 || t_sreq !== 4'b0100) begin
            errors++; $display("FAIL post_reset_read got ok=%b err=%b rdata=%h cyc=%0d s_req=%b exp 1 0 0f0e0d0c 3 0100",
                               t_ok, t_err, t_rd, t_cyc, t_sreq);
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_lanes();
        test_wait_states();
        test_timeout();
        test_decode_errors();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
